// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N shift-and-add multiplier, one CLA step per clock.
// Optional MULT_EARLY_TERM_EN: stop once the remaining multiplier bits are zero.
module carry_lookahead_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;
    logic         cc;
    logic         pp;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is built directly from g/p/cin, not from the previous carry.
    always_comb begin
        c    = '0;
        cc   = 1'b0;
        pp   = 1'b0;
        c[0] = cin;
        for (int i = 0; i < N; i++) begin
            cc = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                cc = cc | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = cc | (pp & cin);
        end
    end

    assign sum  = p ^ c[N-1:0];
    assign cout = c[N];

endmodule

module shift_add_multiplier #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [N-1:0]   acc;
    logic [N-1:0]   q;
    logic [N-1:0]   m;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   addend;
    logic [N-1:0]   sum;
    logic           cout;
    logic [2*N-1:0] shifted;
    logic           early;
    logic           last;

    assign addend = q[0] ? m : '0;

    carry_lookahead_adder #(
        .N(N)
    ) u_cla (
        .a   (acc),
        .b   (addend),
        .cin (1'b0),
        .sum (sum),
        .cout(cout)
    );

    // Carry-out lands in the accumulator MSB after the shift.
    assign shifted = {cout, sum, q[N-1:1]};
    assign last    = (cnt == CW'(1));

`ifdef MULT_EARLY_TERM_EN
    logic [N-1:0] mask;
    assign mask  = ~({N{1'b1}} << cnt);
    assign early = ((q & mask) == '0);
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = CALC;
            CALC: if (early || last) state_nx = DONE;
            DONE: state_nx = start ? CALC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            q       <= '0;
            m       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        m   <= multiplicand;
                        q   <= multiplier;
                        acc <= '0;
                        cnt <= CW'(N);
                    end
                end
                CALC: begin
                    if (early) begin
                        product <= {acc, q} >> cnt;
                    end else begin
                        {acc, q} <= shifted;
                        cnt      <= cnt - CW'(1);
                        if (last) product <= shifted;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (N=8): vector table,
// multi-cycle corner sequences and randomized operands against m*q.
module tb_shift_add_multiplier;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [N-1:0]   m;
        logic [N-1:0]   q;
        logic [2*N-1:0] p;
    } vec_t;

    vec_t vecs[8];

    shift_add_multiplier #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: number of CALC cycles from the multiplier's highest set bit.
    function automatic int exp_calc(input logic [N-1:0] b);
`ifdef MULT_EARLY_TERM_EN
        int hb;
        hb = -1;
        for (int i = 0; i < N; i++) if (b[i]) hb = i;
        if (hb < 0) return 1;
        return (hb + 2 > N) ? N : hb + 2;
`else
        return N;
`endif
    endfunction

    // Counts negedges from the accept edge until done; also counts busy cycles.
    task automatic wait_done(output int waits, output int busy_n);
        waits  = 0;
        busy_n = 0;
        while (waits < 40) begin
            @(negedge clk);
            waits++;
            if (done) break;
            if (busy) busy_n++;
        end
    endtask

    task automatic run_one(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [2*N-1:0] exp_p, input string tag);
        int waits;
        int busy_n;
        @(negedge clk);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = N'($urandom);
        multiplier   = N'($urandom);
        wait_done(waits, busy_n);
        check({tag, "_latency"}, waits, exp_calc(b) + 1);
        check({tag, "_busy"}, busy_n, exp_calc(b));
        check({tag, "_product"}, product, exp_p);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_hold"}, product, exp_p);
    endtask

    initial begin
        int waits;
        int busy_n;
        int pulses;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        vec_t b2b[3];

        vecs[0] = '{8'd13,  8'd11,  16'd143};
        vecs[1] = '{8'd255, 8'd255, 16'd65025};
        vecs[2] = '{8'd0,   8'd200, 16'd0};
        vecs[3] = '{8'd128, 8'd2,   16'd256};
        vecs[4] = '{8'd200, 8'd0,   16'd0};
        vecs[5] = '{8'd5,   8'd1,   16'd5};
        vecs[6] = '{8'd3,   8'd5,   16'd15};
        vecs[7] = '{8'd1,   8'd255, 16'd255};

        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_one(vecs[i].m, vecs[i].q, vecs[i].p, $sformatf("vec%0d", i));

        // start pulsed mid-CALC must be ignored
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 8'd9;
        multiplier   = 8'd135;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("midstart_busy", busy, 1);
        start        = 1'b1;
        multiplicand = 8'd2;
        multiplier   = 8'd3;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                pulses++;
                check("midstart_product", product, 1215);
            end
            @(negedge clk);
        end
        check("midstart_pulses", pulses, 1);
        check("midstart_hold", product, 1215);

        // reset during the 4th CALC cycle
        start        = 1'b1;
        multiplicand = 8'd100;
        multiplier   = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_busy_clr", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_product", product, 0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("rst_mid_quiet", pulses, 0);
        run_one(8'd7, 8'd6, 16'd42, "after_rst");

        // back-to-back with start held high
        b2b[0] = '{8'd3,   8'd5,   16'd15};
        b2b[1] = '{8'd0,   8'd200, 16'd0};
        b2b[2] = '{8'd128, 8'd2,   16'd256};
        @(negedge clk);
        start        = 1'b1;
        multiplicand = b2b[0].m;
        multiplier   = b2b[0].q;
        for (int i = 0; i < 3; i++) begin
            wait_done(waits, busy_n);
            check($sformatf("b2b%0d_spacing", i), waits, exp_calc(b2b[i].q) + 1);
            check($sformatf("b2b%0d_product", i), product, b2b[i].p);
            if (i < 2) begin
                multiplicand = b2b[i+1].m;
                multiplier   = b2b[i+1].q;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_idle", busy, 0);

        // randomized operands against plain multiplication
        for (int k = 0; k < 20; k++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            if (k % 5 == 0) rb = rb >> $urandom_range(N - 1, 0);
            run_one(ra, rb, (2*N)'(ra) * (2*N)'(rb), $sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
